// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus engine: walks every N_IN-bit input vector in binary or Gray order,
// holds each for HOLD_CYC clocks and scores DUT outputs against a golden model.
module truth_table_sweeper #(
  parameter int N_IN     = 4,
  parameter int N_OUT    = 5,
  parameter int HOLD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gray_mode,
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] exp_out,
  output logic [N_IN-1:0]  vec_out,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    err_count,
  output logic [N_OUT-1:0] err_bits,
  output logic [N_IN-1:0]  first_err_vec,
  output logic             first_err_valid
);

  localparam int            HW        = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               gray_q, gray_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [N_IN-1:0]    vec_q, vec_d;
  logic [N_IN:0]      err_count_q, err_count_d;
  logic [N_OUT-1:0]   err_bits_q, err_bits_d;
  logic [N_IN-1:0]    first_err_vec_q, first_err_vec_d;
  logic               first_err_valid_q, first_err_valid_d;

  logic [N_OUT-1:0]   diff;
  logic               sample;
  logic [N_IN-1:0]    idx_inc;

  // Comparison uses the registered vec_out, so the sample cycle sees a settled DUT.
  assign diff    = dut_out ^ exp_out;
  assign sample  = (state_q == S_APPLY) && (hold_q == HOLD_LAST);
  assign idx_inc = idx_q + N_IN'(1);

  // NOTE: every next-state variable takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d           = state_q;
    gray_d            = gray_q;
    idx_d             = idx_q;
    hold_d            = hold_q;
    vec_d             = vec_q;
    err_count_d       = err_count_q;
    err_bits_d        = err_bits_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d           = S_APPLY;
          gray_d            = gray_mode;
          idx_d             = '0;
          hold_d            = '0;
          vec_d             = '0;
          err_count_d       = '0;
          err_bits_d        = '0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
        end
      end
      S_APPLY: begin
        if (sample) begin
          if (|diff) begin
            err_count_d = err_count_q + (N_IN+1)'(1);
            err_bits_d  = err_bits_q | diff;
            if (!first_err_valid_q) begin
              first_err_vec_d   = vec_q;
              first_err_valid_d = 1'b1;
            end
          end
          if (&idx_q) begin
            state_d = S_DONE;
          end else begin
            idx_d  = idx_inc;
            hold_d = '0;
            vec_d  = gray_q ? (idx_inc ^ (idx_inc >> 1)) : idx_inc;
          end
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= S_IDLE;
      gray_q            <= 1'b0;
      idx_q             <= '0;
      hold_q            <= '0;
      vec_q             <= '0;
      err_count_q       <= '0;
      err_bits_q        <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      gray_q            <= gray_d;
      idx_q             <= idx_d;
      hold_q            <= hold_d;
      vec_q             <= vec_d;
      err_count_q       <= err_count_d;
      err_bits_q        <= err_bits_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
    end
  end

  assign vec_out         = vec_q;
  assign busy            = (state_q == S_APPLY);
  assign done            = (state_q == S_DONE);
  assign err_count       = err_count_q;
  assign err_bits        = err_bits_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_valid = first_err_valid_q;

endmodule
